// File: rtl/ib_align_ctrl.sv
// Transfer controller for an 8-byte byte-alignment unit: it counts input and output
// beats and flags the first and last word on each side.
module ib_align_ctrl #(
    parameter int unsigned LEN_WIDTH = 12
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ_VLD,
    output logic                 REQ_RDY,
    input  logic [2:0]           REQ_SRC_ADDR,
    input  logic [2:0]           REQ_DST_ADDR,
    input  logic [LEN_WIDTH-1:0] REQ_LEN,
    output logic [2:0]           AU_SRC_ADDR,
    output logic [2:0]           AU_DST_ADDR,
    output logic                 IN_EN,
    input  logic                 IN_SRC_RDY,
    input  logic                 IN_DST_RDY,
    output logic                 IN_SOF,
    output logic                 IN_EOF,
    output logic                 OUT_EN,
    input  logic                 OUT_SRC_RDY,
    input  logic                 OUT_DST_RDY,
    output logic                 OUT_SOF,
    output logic                 OUT_EOF,
    output logic [7:0]           OUT_EOF_BE,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned CW = LEN_WIDTH - 2;
    localparam int unsigned SW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt, out_cnt, in_words, out_words;
    logic [SW-1:0]   eff_len, dst_end;
    logic [CW-1:0]   in_words_nx, out_words_nx;
    logic [2:0]      last_byte;
    logic [7:0]      be_nx;
    logic            accept, in_beat, out_beat;

    // Word counts are derived with one spare bit so the 2^LEN_WIDTH case cannot wrap.
    assign eff_len      = (REQ_LEN == '0) ? (SW'(1) << LEN_WIDTH) : SW'(REQ_LEN);
    assign in_words_nx  = CW'((SW'(REQ_SRC_ADDR) + eff_len + SW'(7)) >> 3);
    assign out_words_nx = CW'((SW'(REQ_DST_ADDR) + eff_len + SW'(7)) >> 3);
    assign dst_end      = SW'(REQ_DST_ADDR) + eff_len - SW'(1);
    assign last_byte    = dst_end[2:0];
    assign be_nx        = 8'hFF >> (3'd7 - last_byte);

    assign accept   = (state_q == S_IDLE) && REQ_VLD;
    assign in_beat  = IN_EN && IN_SRC_RDY && IN_DST_RDY;
    assign out_beat = OUT_EN && OUT_SRC_RDY && OUT_DST_RDY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        REQ_RDY = 1'b0;
        IN_EN   = 1'b0;
        OUT_EN  = 1'b0;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            S_IDLE: begin
                REQ_RDY = 1'b1;
                if (REQ_VLD) state_d = S_RUN;
            end
            S_RUN: begin
                BUSY   = 1'b1;
                IN_EN  = (in_cnt < in_words);
                OUT_EN = (out_cnt < out_words);
                // The last output word ends the transfer whatever the input side is doing.
                if (OUT_EN && OUT_SRC_RDY && OUT_DST_RDY && (out_cnt == out_words - CW'(1)))
                    state_d = S_DONE;
            end
            S_DONE: begin
                BUSY    = 1'b1;
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign IN_SOF  = IN_EN && (in_cnt == '0);
    assign IN_EOF  = IN_EN && (in_cnt == in_words - CW'(1));
    assign OUT_SOF = OUT_EN && (out_cnt == '0);
    assign OUT_EOF = OUT_EN && (out_cnt == out_words - CW'(1));

    // Request parameters and beat counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            in_words    <= '0;
            out_words   <= '0;
            AU_SRC_ADDR <= '0;
            AU_DST_ADDR <= '0;
            OUT_EOF_BE  <= '0;
        end else if (accept) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            in_words    <= in_words_nx;
            out_words   <= out_words_nx;
            AU_SRC_ADDR <= REQ_SRC_ADDR;
            AU_DST_ADDR <= REQ_DST_ADDR;
            OUT_EOF_BE  <= be_nx;
        end else begin
            if (in_beat)  in_cnt  <= in_cnt + CW'(1);
            if (out_beat) out_cnt <= out_cnt + CW'(1);
        end
    end

endmodule
